// File: rtl/program_memory.sv
// program_memory
// Unified 2^ADDR_W x 16 program/data memory for the accumulator processor,
// fronted by a byte-stream program loader.
//
// After reset the loader holds the processor in reset (cpu_rst_n low) and
// accepts a length-prefixed, big-endian image from an 8-bit valid/ready
// stream: two count bytes (high first), then count words of two bytes each,
// written from address 0 upward. Once the final byte is accepted the block
// enters RUN, releases the processor and pulses load_done for one cycle.
// In RUN the processor owns the write port; ld_start returns to loading.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   ld_valid, ld_byte    load byte stream (in)
//   ld_ready             loader accepts a byte this cycle (state decode)
//   ld_start             one-cycle reload request, honoured only in RUN
//   cpu_rst_n            processor reset, active-low, low while loading
//   load_done            one-cycle pulse on entry to RUN
//   cpu_addr             processor address (read in all states, write in RUN)
//   cpu_din, cpu_we      processor write data / enable (RUN only)
//   mem_q                registered read data, read-first on collisions
module program_memory #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    input  logic              ld_start,
    output logic              cpu_rst_n,
    output logic              load_done,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] mem_q
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DAT_HI = 3'd2,
        DAT_LO = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]     count_q, count_d;       // one extra bit holds 2^ADDR_W
    logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                load_done_q, load_done_d;
    logic [DATA_W-1:0]   mem_q_q, mem_q_d;

    logic                ld_accept_s;
    logic [15:0]         full_cnt_s;
    logic [ADDR_W:0]     clamped_cnt_s;
    logic [ADDR_W:0]     word_next_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_wa_s;
    logic [DATA_W-1:0]   mem_wd_s;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    assign ld_ready    = (state_q != RUN);
    assign ld_accept_s = ld_valid && ld_ready;
    assign full_cnt_s  = {cnt_hi_q, ld_byte};
    assign word_next_s = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign cpu_rst_n   = cpu_rst_n_q;
    assign load_done   = load_done_q;
    assign mem_q       = mem_q_q;

    // Clamp the 16-bit image length to the memory depth.
    always_comb begin
        if (32'(full_cnt_s) > DEPTH) begin
            clamped_cnt_s = (ADDR_W+1)'(DEPTH);
        end else begin
            clamped_cnt_s = (ADDR_W+1)'(full_cnt_s);
        end
    end

    // Loader FSM next-state logic and memory write-port steering.
    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        load_addr_d = load_addr_q;
        word_cnt_d  = word_cnt_q;
        hi_d        = hi_q;
        cpu_rst_n_d = cpu_rst_n_q;
        load_done_d = 1'b0;
        mem_we_s    = 1'b0;
        mem_wa_s    = cpu_addr;
        mem_wd_s    = cpu_din;
        mem_q_d     = mem[cpu_addr];

        case (state_q)
            CNT_HI: begin
                if (ld_accept_s) begin
                    cnt_hi_d = ld_byte;
                    state_d  = CNT_LO;
                end else begin
                    state_d  = CNT_HI;
                end
            end
            CNT_LO: begin
                if (ld_accept_s) begin
                    count_d = clamped_cnt_s;
                    if (clamped_cnt_s == {(ADDR_W+1){1'b0}}) begin
                        // Empty image: go straight to RUN, memory untouched.
                        state_d     = RUN;
                        cpu_rst_n_d = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        load_addr_d = {ADDR_W{1'b0}};
                        word_cnt_d  = {(ADDR_W+1){1'b0}};
                        state_d     = DAT_HI;
                    end
                end else begin
                    state_d = CNT_LO;
                end
            end
            DAT_HI: begin
                if (ld_accept_s) begin
                    hi_d    = ld_byte;
                    state_d = DAT_LO;
                end else begin
                    state_d = DAT_HI;
                end
            end
            DAT_LO: begin
                if (ld_accept_s) begin
                    mem_we_s    = 1'b1;
                    mem_wa_s    = load_addr_q;
                    mem_wd_s    = DATA_W'({hi_q, ld_byte});
                    load_addr_d = load_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    word_cnt_d  = word_next_s;
                    if (word_next_s == count_q) begin
                        state_d     = RUN;
                        cpu_rst_n_d = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        state_d     = DAT_HI;
                    end
                end else begin
                    state_d = DAT_LO;
                end
            end
            RUN: begin
                // A write requested together with ld_start still completes.
                if (cpu_we) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (ld_start) begin
                    state_d     = CNT_HI;
                    cpu_rst_n_d = 1'b0;
                    cnt_hi_d    = 8'd0;
                    count_d     = {(ADDR_W+1){1'b0}};
                end else begin
                    state_d     = RUN;
                end
            end
            default: begin
                state_d     = CNT_HI;
                cpu_rst_n_d = 1'b0;
            end
        endcase
    end

    // Control registers and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CNT_HI;
            cnt_hi_q    <= 8'd0;
            count_q     <= {(ADDR_W+1){1'b0}};
            load_addr_q <= {ADDR_W{1'b0}};
            word_cnt_q  <= {(ADDR_W+1){1'b0}};
            hi_q        <= 8'd0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            mem_q_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            count_q     <= count_d;
            load_addr_q <= load_addr_d;
            word_cnt_q  <= word_cnt_d;
            hi_q        <= hi_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
            mem_q_q     <= mem_q_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_start;
    logic        cpu_rst_n;
    logic        load_done;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        cpu_we;
    logic [15:0] mem_q;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: plain array of words as seen by the processor.
    logic [15:0] model [0:4095];

    program_memory #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_ready(ld_ready), .ld_start(ld_start), .cpu_rst_n(cpu_rst_n),
        .load_done(load_done), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_we(cpu_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one byte and return at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        while (ld_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            chk_cnt++;
            $display("FAIL send_byte_timeout got ld_ready=%b want 1", ld_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ld_start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_start = 1'b0;
        cpu_addr = 12'h000; cpu_din = 16'h0000; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b want 1", ld_ready); else pass_cnt++;
        chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL reset_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (load_done !== 1'b0) $display("FAIL reset_load_done got %b want 0", load_done); else pass_cnt++;
        chk_cnt++; if (mem_q !== 16'h0000) $display("FAIL reset_mem_q got %h want 0000", mem_q); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL post_reset_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
    endtask

    task automatic test_basic_load();
        logic [7:0] img [0:7];
        img = '{8'h00, 8'h03, 8'hA0, 8'h05, 8'h20, 8'h0A, 8'h60, 8'h00};
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i]);
            if (i == 6) begin
                chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL basic_rst_before_last got %b want 0", cpu_rst_n); else pass_cnt++;
                chk_cnt++; if (load_done !== 1'b0) $display("FAIL basic_done_before_last got %b want 0", load_done); else pass_cnt++;
            end
        end
        ld_valid = 1'b0;
        chk_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL basic_cpu_rst_n got %b want 1", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (load_done !== 1'b1) $display("FAIL basic_load_done got %b want 1", load_done); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b0) $display("FAIL basic_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (load_done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", load_done); else pass_cnt++;
        model[0] = 16'hA005; model[1] = 16'h200A; model[2] = 16'h6000;
        for (int a = 0; a < 3; a++) begin
            cpu_addr = 12'(a);
            @(negedge clk);
            chk_cnt++; if (mem_q !== model[a]) $display("FAIL basic_mem[%0d] got %h want %h", a, mem_q, model[a]); else pass_cnt++;
        end
    endtask

    task automatic test_zero_count();
        pulse_ld_start();
        chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL zero_start_rst got %b want 0", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b1) $display("FAIL zero_start_ready got %b want 1", ld_ready); else pass_cnt++;
        send_byte(8'h00);
        chk_cnt++; if (ld_ready !== 1'b1) $display("FAIL zero_mid_ready got %b want 1", ld_ready); else pass_cnt++;
        send_byte(8'h00);
        ld_valid = 1'b0;
        chk_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL zero_cpu_rst_n got %b want 1", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (load_done !== 1'b1) $display("FAIL zero_load_done got %b want 1", load_done); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b0) $display("FAIL zero_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        for (int a = 0; a < 3; a++) begin
            cpu_addr = 12'(a);
            @(negedge clk);
            chk_cnt++; if (mem_q !== model[a]) $display("FAIL zero_mem[%0d] got %h want %h", a, mem_q, model[a]); else pass_cnt++;
        end
    endtask

    task automatic test_read_first();
        logic [15:0] v;
        v = 16'($urandom);
        cpu_addr = 12'h0FF; cpu_din = v; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        model[12'h0FF] = v;
        @(negedge clk);
        chk_cnt++; if (mem_q !== v) $display("FAIL rf_setup got %h want %h", mem_q, v); else pass_cnt++;
        cpu_din = 16'h1234; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        chk_cnt++; if (mem_q !== v) $display("FAIL rf_old_data got %h want %h", mem_q, v); else pass_cnt++;
        model[12'h0FF] = 16'h1234;
        @(negedge clk);
        chk_cnt++; if (mem_q !== 16'h1234) $display("FAIL rf_new_data got %h want 1234", mem_q); else pass_cnt++;
    endtask

    task automatic test_valid_toggle();
        logic [7:0]  img [0:5];
        logic [15:0] w0, w1;
        logic        rdy;
        int          idx = 0;
        int          used = 0;
        w0 = 16'($urandom); w1 = 16'($urandom);
        img = '{8'h00, 8'h02, w0[15:8], w0[7:0], w1[15:8], w1[7:0]};
        pulse_ld_start();
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            ld_valid = (cyc % 2) == 1;
            ld_byte  = img[idx];
            rdy      = ld_ready;
            @(posedge clk);
            if (ld_valid && rdy) idx++;
            @(negedge clk);
            used = cyc + 1;
        end
        ld_valid = 1'b0;
        chk_cnt++; if (idx !== 6) $display("FAIL toggle_bytes got %0d want 6", idx); else pass_cnt++;
        chk_cnt++; if (used !== 12) $display("FAIL toggle_cycles got %0d want 12", used); else pass_cnt++;
        chk_cnt++; if (load_done !== 1'b1) $display("FAIL toggle_load_done got %b want 1", load_done); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b0) $display("FAIL toggle_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        model[0] = w0; model[1] = w1;
        for (int a = 0; a < 3; a++) begin
            cpu_addr = 12'(a);
            @(negedge clk);
            chk_cnt++; if (mem_q !== model[a]) $display("FAIL toggle_mem[%0d] got %h want %h", a, mem_q, model[a]); else pass_cnt++;
        end
    endtask

    task automatic test_midload_reset();
        logic [7:0] img [0:3];
        img = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        pulse_ld_start();
        send_byte(8'h00); send_byte(8'h03); send_byte(8'($urandom));
        ld_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_cnt++; if (ld_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", ld_ready); else pass_cnt++;
        chk_cnt++; if (mem_q !== 16'h0000) $display("FAIL mid_rst_mem_q got %h want 0000", mem_q); else pass_cnt++;
        rst_n = 1'b1;
        cpu_addr = 12'h002; cpu_din = 16'hFFFF; cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(img[i]);
            if (i < 3) begin
                chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL mid_cpu_rst_n_byte%0d got %b want 0", i, cpu_rst_n); else pass_cnt++;
            end
        end
        cpu_we = 1'b0; ld_valid = 1'b0;
        chk_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL mid_cpu_rst_n_done got %b want 1", cpu_rst_n); else pass_cnt++;
        model[0] = 16'hBEEF;
        cpu_addr = 12'h000;
        @(negedge clk);
        chk_cnt++; if (mem_q !== 16'hBEEF) $display("FAIL mid_mem0 got %h want BEEF", mem_q); else pass_cnt++;
        cpu_addr = 12'h002;
        @(negedge clk);
        chk_cnt++; if (mem_q !== model[2]) $display("FAIL mid_mem2_we_ignored got %h want %h", mem_q, model[2]); else pass_cnt++;
    endtask

    task automatic test_clamp();
        logic [15:0] w;
        pulse_ld_start();
        send_byte(8'hFF); send_byte(8'hFF);
        for (int a = 0; a < 4096; a++) begin
            w = 16'($urandom);
            model[a] = w;
            send_byte(w[15:8]);
            if (a == 4095) begin
                chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL clamp_rst_at_8193 got %b want 0", cpu_rst_n); else pass_cnt++;
            end
            send_byte(w[7:0]);
        end
        chk_cnt++; if (load_done !== 1'b1) $display("FAIL clamp_load_done got %b want 1", load_done); else pass_cnt++;
        chk_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL clamp_cpu_rst_n got %b want 1", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b0) $display("FAIL clamp_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        // Extra bytes offered in RUN must be refused.
        ld_byte = 8'h5A;
        @(negedge clk);
        chk_cnt++; if (ld_ready !== 1'b0) $display("FAIL clamp_run_refuse got %b want 0", ld_ready); else pass_cnt++;
        ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int a;
            a = (k == 0) ? 0 : (k == 1) ? 4095 : int'($urandom_range(0, 4095));
            cpu_addr = 12'(a);
            @(negedge clk);
            chk_cnt++; if (mem_q !== model[a]) $display("FAIL clamp_mem[%0d] got %h want %h", a, mem_q, model[a]); else pass_cnt++;
        end
    endtask

    task automatic test_random_run();
        logic [15:0] exp_q;
        for (int n = 0; n < 300; n++) begin
            cpu_addr = 12'($urandom_range(0, 4095));
            if (n % 3 == 0) cpu_addr = 12'($urandom_range(0, 7));
            cpu_din  = 16'($urandom);
            cpu_we   = 1'($urandom_range(0, 1));
            exp_q    = model[cpu_addr];
            @(negedge clk);
            chk_cnt++; if (mem_q !== exp_q) $display("FAIL run_read[%0d] addr %h got %h want %h", n, cpu_addr, mem_q, exp_q); else pass_cnt++;
            if (cpu_we) model[cpu_addr] = cpu_din;
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] old;
        a = 12'($urandom); d = 16'($urandom); old = model[a];
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1; ld_start = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0; ld_start = 1'b0;
        chk_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL b2b_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        chk_cnt++; if (ld_ready !== 1'b1) $display("FAIL b2b_ld_ready got %b want 1", ld_ready); else pass_cnt++;
        chk_cnt++; if (mem_q !== old) $display("FAIL b2b_old got %h want %h", mem_q, old); else pass_cnt++;
        model[a] = d;
        @(negedge clk);
        chk_cnt++; if (mem_q !== d) $display("FAIL b2b_write got %h want %h", mem_q, d); else pass_cnt++;
        send_byte(8'h00); send_byte(8'h00);
        ld_valid = 1'b0;
        chk_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL b2b_reload got %b want 1", cpu_rst_n); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_count();
        test_read_first();
        test_valid_toggle();
        test_midload_reset();
        test_clamp();
        test_random_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
